// File: rtl/portgroup_pkg.sv
// Shared types and constants for the port-group receive path.
package portgroup_pkg;

  typedef enum logic [1:0] {
    DIS   = 2'd0,
    IDLE  = 2'd1,
    SHIFT = 2'd2
  } rx_state_e;

  localparam int OVF_W = 8;
  localparam logic [OVF_W-1:0] OVF_SAT = '1;

  // Overflow counter sticks at its maximum instead of wrapping.
  function automatic logic [OVF_W-1:0] ovf_inc(input logic [OVF_W-1:0] cnt);
    return (cnt == OVF_SAT) ? cnt : cnt + OVF_W'(1);
  endfunction

endpackage

// File: rtl/portgroup_rx_shift.sv
// MSB-first shift register with bit counter; sof restarts the word, clr aborts it.
// Latency: word_nxt/last are combinational from the accepted bit; no backpressure.
module portgroup_rx_shift #(
  parameter int width_p = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               restart,
  input  logic               bit_in,
  output logic [width_p-1:0] word_nxt,
  output logic               last
);

  localparam int CW = $clog2(width_p + 1);

  logic [width_p-1:0] sr;
  logic [width_p-1:0] shifted;
  logic [width_p-1:0] fresh;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nxt;

  generate
    if (width_p == 1) begin : g_w1
      assign shifted = bit_in;
      assign fresh   = bit_in;
    end else begin : g_wn
      assign shifted = {sr[width_p-2:0], bit_in};
      assign fresh   = {{(width_p-1){1'b0}}, bit_in};
    end
  endgenerate

  assign cnt_nxt  = restart ? CW'(1) : cnt + CW'(1);
  assign word_nxt = restart ? fresh : shifted;
  assign last     = shift_en & (cnt_nxt == CW'(width_p));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= word_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/portgroup_rx.sv
// Deserialises the rx bit stream into words for regf rx_data0 and tracks full/overflow status.
// Latency: commit and status outputs register 1 cycle after the last bit; no backpressure, excess words count as overflow.
module portgroup_rx
  import portgroup_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               main_clk_i,
  input  logic               main_rst_i,
  input  logic               regf_ctrl_ena_rval_i,
  input  logic               rx_bit_i,
  input  logic               rx_bit_vld_i,
  input  logic               rx_sof_i,
  input  logic               regf_rx_data0_rd_i,
  output logic [width_p-1:0] regf_rx_data0_wval_o,
  output logic               regf_rx_data0_wr_o,
  output logic               regf_rx_stat_full_wval_o,
  output logic [OVF_W-1:0]   regf_rx_stat_ovf_wval_o,
  output logic               regf_rx_stat_wr_o,
  output logic               irq_o
);

  rx_state_e          state;
  logic               ena;
  logic               shift_en;
  logic               last;
  logic               wr_nxt;
  logic               full_nxt;
  logic [OVF_W-1:0]   ovf_nxt;
  logic [width_p-1:0] word_nxt;

  assign ena      = regf_ctrl_ena_rval_i;
  assign shift_en = ena & rx_bit_vld_i &
                    (((state == IDLE) & rx_sof_i) | (state == SHIFT));

  portgroup_rx_shift #(
    .width_p (width_p)
  ) u_shift (
    .clk      (main_clk_i),
    .rst      (main_rst_i),
    .clr      (~ena),
    .shift_en (shift_en),
    .restart  (rx_sof_i),
    .bit_in   (rx_bit_i),
    .word_nxt (word_nxt),
    .last     (last)
  );

  // A read landing with a commit frees the slot for the new word.
  always_comb begin
    wr_nxt   = 1'b0;
    full_nxt = regf_rx_stat_full_wval_o;
    ovf_nxt  = regf_rx_stat_ovf_wval_o;
    if (last) begin
      if (!regf_rx_stat_full_wval_o || regf_rx_data0_rd_i) begin
        wr_nxt   = 1'b1;
        full_nxt = 1'b1;
      end else begin
        ovf_nxt = ovf_inc(regf_rx_stat_ovf_wval_o);
      end
    end else if (regf_rx_data0_rd_i) begin
      full_nxt = 1'b0;
    end
  end

  always_ff @(posedge main_clk_i or posedge main_rst_i) begin
    if (main_rst_i) begin
      state                    <= DIS;
      regf_rx_data0_wval_o     <= '0;
      regf_rx_data0_wr_o       <= 1'b0;
      regf_rx_stat_full_wval_o <= 1'b0;
      regf_rx_stat_ovf_wval_o  <= '0;
      regf_rx_stat_wr_o        <= 1'b0;
      irq_o                    <= 1'b0;
    end else begin
      if (!ena) begin
        state <= DIS;
      end else begin
        case (state)
          DIS:     state <= IDLE;
          IDLE:    if (shift_en && !last) state <= SHIFT;
          SHIFT:   if (last) state <= IDLE;
          default: state <= DIS;
        endcase
      end
      regf_rx_data0_wr_o <= wr_nxt;
      if (wr_nxt) regf_rx_data0_wval_o <= word_nxt;
      regf_rx_stat_full_wval_o <= full_nxt;
      regf_rx_stat_ovf_wval_o  <= ovf_nxt;
      regf_rx_stat_wr_o        <= (full_nxt != regf_rx_stat_full_wval_o) |
                                  (ovf_nxt != regf_rx_stat_ovf_wval_o);
      irq_o                    <= full_nxt & ena;
    end
  end

endmodule

// File: tb/tb_portgroup_rx.sv
// Randomised scoreboard bench for portgroup_rx (width 8) plus a short width-1 run.
module tb_portgroup_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0, vld = 1'b0, sof = 1'b0, bitv = 1'b0, rd = 1'b0;
  logic [7:0] d_wval;
  logic       d_wr, s_full, s_wr, irq;
  logic [7:0] s_ovf;

  logic v1 = 1'b0, s1 = 1'b0, b1 = 1'b0, r1 = 1'b0;
  logic [0:0] d1_wval;
  logic       d1_wr, s1_full, s1_wr, irq1;
  logic [7:0] s1_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  portgroup_rx #(.width_p(8)) u_dut (
    .main_clk_i               (clk),
    .main_rst_i               (rst),
    .regf_ctrl_ena_rval_i     (ena),
    .rx_bit_i                 (bitv),
    .rx_bit_vld_i             (vld),
    .rx_sof_i                 (sof),
    .regf_rx_data0_rd_i       (rd),
    .regf_rx_data0_wval_o     (d_wval),
    .regf_rx_data0_wr_o       (d_wr),
    .regf_rx_stat_full_wval_o (s_full),
    .regf_rx_stat_ovf_wval_o  (s_ovf),
    .regf_rx_stat_wr_o        (s_wr),
    .irq_o                    (irq)
  );

  portgroup_rx #(.width_p(1)) u_dut1 (
    .main_clk_i               (clk),
    .main_rst_i               (rst),
    .regf_ctrl_ena_rval_i     (ena),
    .rx_bit_i                 (b1),
    .rx_bit_vld_i             (v1),
    .rx_sof_i                 (s1),
    .regf_rx_data0_rd_i       (r1),
    .regf_rx_data0_wval_o     (d1_wval),
    .regf_rx_data0_wr_o       (d1_wr),
    .regf_rx_stat_full_wval_o (s1_full),
    .regf_rx_stat_ovf_wval_o  (s1_ovf),
    .regf_rx_stat_wr_o        (s1_wr),
    .irq_o                    (irq1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: bits collected since the last sof form a word once width bits arrive.
  typedef struct packed {int c; logic [7:0] data;} dexp_t;
  typedef struct packed {int c; logic full; logic [7:0] ovf;} sexp_t;
  dexp_t q_data[$];
  sexp_t q_stat[$];
  bit    m_bits[$];
  logic  m_full = 1'b0, m_irq = 1'b0, m_prev_ena = 1'b0;
  logic [7:0] m_ovf = '0, m_wval = '0;

  always @(posedge clk) begin
    logic [7:0] word;
    logic nf;
    logic [7:0] no;
    bit commit;
    cyc++;
    if (rst) begin
      m_bits.delete(); q_data.delete(); q_stat.delete();
      m_full = 0; m_ovf = 0; m_wval = 0; m_irq = 0; m_prev_ena = 0;
    end else begin
      commit = 0;
      word = 0;
      if (!ena) m_bits.delete();
      else if (m_prev_ena && vld) begin
        if (sof) begin m_bits.delete(); m_bits.push_back(bitv); end
        else if (m_bits.size() > 0) m_bits.push_back(bitv);
        if (m_bits.size() == 8) begin
          foreach (m_bits[i]) word = (word << 1) | 8'(m_bits[i]);
          m_bits.delete();
          commit = 1;
        end
      end
      nf = m_full;
      no = m_ovf;
      if (commit && (!m_full || rd)) begin
        nf = 1; m_wval = word; q_data.push_back('{cyc, word});
      end else if (commit) begin
        if (no < 8'd255) no = no + 8'd1;
      end else if (rd) nf = 0;
      if (nf != m_full || no != m_ovf) q_stat.push_back('{cyc, nf, no});
      m_full = nf; m_ovf = no; m_irq = nf & ena; m_prev_ena = ena;
    end
  end

  always @(negedge clk) begin
    dexp_t d;
    sexp_t s;
    if (rst) begin
      chk("rst_data_wr", d_wr, 0);  chk("rst_wval", d_wval, 0);
      chk("rst_full", s_full, 0);   chk("rst_ovf", s_ovf, 0);
      chk("rst_stat_wr", s_wr, 0);  chk("rst_irq", irq, 0);
    end else begin
      if (d_wr) begin
        if (q_data.size() == 0) chk("data_wr_unexpected", d_wr, 0);
        else begin
          d = q_data.pop_front();
          chk("data_wr_cycle", cyc, d.c);
          chk("data_wr_wval", d_wval, d.data);
        end
      end else if (q_data.size() > 0 && q_data[0].c <= cyc) begin
        d = q_data.pop_front();
        chk("data_wr_missing", d_wr, 1);
      end
      if (s_wr) begin
        if (q_stat.size() == 0) chk("stat_wr_unexpected", s_wr, 0);
        else begin
          s = q_stat.pop_front();
          chk("stat_wr_cycle", cyc, s.c);
          chk("stat_wr_full", s_full, s.full);
          chk("stat_wr_ovf", s_ovf, s.ovf);
        end
      end else if (q_stat.size() > 0 && q_stat[0].c <= cyc) begin
        s = q_stat.pop_front();
        chk("stat_wr_missing", s_wr, 1);
      end
      chk("wval_hold", d_wval, m_wval);
      chk("full_val", s_full, m_full);
      chk("ovf_val", s_ovf, m_ovf);
      chk("irq_val", irq, m_irq);
    end
  end

  task automatic step(input logic e, input logic v, input logic s, input logic b, input logic r);
    ena = e; vld = v; sof = s; bitv = b; rd = r;
    @(posedge clk);
    #1;
    vld = 0; sof = 0; rd = 0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit rd_last, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      if (gaps)
        repeat ($urandom_range(0, 2)) step(1, 0, 1'($urandom), 1'($urandom), 0);
      step(1, 1, i == 7, w[i], rd_last && i == 0);
    end
  endtask

  initial begin
    logic lastb;
    logic b;
    repeat (3) step(0, 0, 0, 0, 0);
    rst = 0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, i == 0, 1'($urandom), 0);
    rst = 1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    rst = 0;
    step(1, 0, 0, 0, 0);

    send_word(8'hA5, 0, 1);
    chk("a5_wr", d_wr, 1); chk("a5_wval", d_wval, 8'hA5);
    chk("a5_full", s_full, 1); chk("a5_stat_wr", s_wr, 1); chk("a5_irq", irq, 1);

    send_word(8'h3C, 0, 1);
    chk("ovf_no_wr", d_wr, 0); chk("ovf_wval_kept", d_wval, 8'hA5); chk("ovf_cnt1", s_ovf, 1);

    send_word(8'h5A, 1, 1);
    chk("coll_wr", d_wr, 1); chk("coll_wval", d_wval, 8'h5A);
    chk("coll_full", s_full, 1); chk("coll_ovf", s_ovf, 1); chk("coll_no_stat", s_wr, 0);

    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, i == 0, 1'($urandom), 0);
    send_word(8'h81, 0, 0);
    chk("restart_wval", d_wval, 8'h81); chk("restart_full", s_full, 1);

    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1'($urandom), 0);
    chk("nosof_full", s_full, 0); chk("nosof_wval", d_wval, 8'h81);

    send_word(8'hC3, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, i == 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("dis_irq", irq, 0); chk("dis_full_kept", s_full, 1); chk("dis_ovf_kept", s_ovf, 1);
    step(0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    chk("reen_irq", irq, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
    send_word(8'hFF, 0, 0);
    chk("ff_wval", d_wval, 8'hFF); chk("ff_ovf_kept", s_ovf, 1);

    for (int i = 0; i < 300; i++) send_word(8'($urandom), 0, i % 4 == 0);
    chk("ovf_sat", s_ovf, 255); chk("sat_full", s_full, 1);

    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 15) != 0), 1'($urandom), ($urandom_range(0, 7) == 0),
           1'($urandom), ($urandom_range(0, 9) == 0));
    repeat (3) step(1, 0, 0, 0, 0);
    chk("q_data_drained", q_data.size(), 0);
    chk("q_stat_drained", q_stat.size(), 0);

    lastb = 0;
    for (int i = 0; i < 8; i++) begin
      b = 1'($urandom);
      v1 = 1; s1 = 1; b1 = b; r1 = 1;
      step(1, 0, 0, 0, 0);
      v1 = 0; s1 = 0; r1 = 0;
      chk("w1_wr", d1_wr, 1); chk("w1_wval", d1_wval, b); chk("w1_full", s1_full, 1);
      lastb = b;
    end
    v1 = 1; s1 = 0; b1 = ~lastb;
    step(1, 0, 0, 0, 0);
    v1 = 0;
    chk("w1_nosof_wr", d1_wr, 0);
    v1 = 1; s1 = 1; b1 = ~lastb;
    step(1, 0, 0, 0, 0);
    v1 = 0; s1 = 0;
    chk("w1_ovf_no_wr", d1_wr, 0); chk("w1_ovf_wval", d1_wval, lastb); chk("w1_ovf", s1_ovf, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
